// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: opcode constants,
// FSM state encoding, default register-index width and source-use decode.
package hazard_pkg;

  localparam int REG_W_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  // rs is read by everything except the jumps and LUI
  function automatic logic rs_used(input logic [5:0] op);
    return !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
  endfunction

  // rt is a source only for R-type, the compare branches and stores
  function automatic logic rt_used(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline-side signal bundle of the hazard controller. The pipeline
// (master) supplies decode/EX/memory status, the controller (slave) returns
// the enables, flushes and statistics.
interface hazard_ctrl_mc_if
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 32
);
  logic [31:0]      ID_Instruction;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_RtReg;
  logic             BranchTaken;
  logic             MemBusy;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Hold;
  logic             StallActive;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_Instruction, EX_MemRead, EX_RtReg, BranchTaken, MemBusy,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold,
           StallActive, StallCount, FlushCount
  );

  modport slave (
    input  ID_Instruction, EX_MemRead, EX_RtReg, BranchTaken, MemBusy,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold,
           StallActive, StallCount, FlushCount
  );
endinterface

// File: rtl/load_pending_pipe.sv
// Tracks loads that have left EX but whose data is not yet forwardable.
// DEPTH entries of {valid, rt}; shifts every un-frozen cycle and reports
// whether either (pre-masked) source register matches a valid entry.
// Register 0 never matches; callers pass 0 for an unused source.
module load_pending_pipe
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             in_valid,
  input  logic [REG_W-1:0] in_reg,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  output logic             match
);

  if (DEPTH == 0) begin : g_none
    logic unused_in;
    assign unused_in = ^{clk, rst_n, freeze, in_valid, in_reg, src_a, src_b};
    assign match = 1'b0;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_r;
    logic [REG_W-1:0] rt_r [DEPTH];

    // Shift register of in-flight loads; holds its contents while frozen
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= '0;
        for (int i = 0; i < DEPTH; i++) rt_r[i] <= '0;
      end else if (!freeze) begin
        valid_r[0] <= in_valid;
        rt_r[0]    <= in_reg;
        for (int i = 1; i < DEPTH; i++) begin
          valid_r[i] <= valid_r[i-1];
          rt_r[i]    <= rt_r[i-1];
        end
      end
    end

    // Compare both sources against every valid, non-zero entry
    always_comb begin
      match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && (rt_r[i] != '0) && ((rt_r[i] == src_a) || (rt_r[i] == src_b))) begin
          match = 1'b1;
        end else begin
          match = match;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/stall controller for the 5-stage MIPS pipeline (beside ID).
// Load-use detection against EX and in-flight loads, multi-cycle branch
// flush, and whole-pipe freeze while data memory is busy.
// Optional statistics counters are built when STALL_STATS_EN is defined.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic              Clk,
  input logic              Reset_n,
  hazard_ctrl_mc_if.slave  bus
);

  localparam int         DEPTH     = LOAD_LAT - 1;
  localparam logic [2:0] FC_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [5:0]       opcode;
  logic [REG_W-1:0] src_a, src_b;
  logic             ex_match, pipe_match, hazard;
  state_t           state_r, state_n, eff_state;
  logic [2:0]       cnt_r, cnt_n;
  logic             pend_r, pend_n, eff_branch;
  logic             pc_write, if_id_write, flush_s, hold_s, stall_s;
  logic             unused_imm;

  assign opcode     = bus.ID_Instruction[31:26];
  assign src_a      = rs_used(opcode) ? REG_W'(bus.ID_Instruction[25:21]) : '0;
  assign src_b      = rt_used(opcode) ? REG_W'(bus.ID_Instruction[20:16]) : '0;
  assign unused_imm = ^bus.ID_Instruction[15:0];
  assign ex_match   = bus.EX_MemRead && (bus.EX_RtReg != '0) &&
                      ((bus.EX_RtReg == src_a) || (bus.EX_RtReg == src_b));
  assign hazard     = ex_match | pipe_match;

  // A load squashed by a branch flush never produces data, so it is not tracked
  load_pending_pipe #(.REG_W(REG_W), .DEPTH(DEPTH)) u_pipe (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .freeze   (bus.MemBusy),
    .in_valid (bus.EX_MemRead & ~flush_s),
    .in_reg   (bus.EX_RtReg),
    .src_a    (src_a),
    .src_b    (src_b),
    .match    (pipe_match)
  );

  // FSM state, flush counter and flush-pending flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      pend_r  <= pend_n;
    end
  end

  // Next-state and control outputs; MemBusy > BranchTaken > load-use
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    pend_n      = pend_r;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush_s     = 1'b0;
    hold_s      = 1'b0;
    stall_s     = 1'b0;
    eff_branch  = bus.BranchTaken;
    // On leaving MEMWAIT the release cycle behaves like the state it resumes
    if (state_r == MEMWAIT) begin
      if (pend_r) begin
        eff_state  = IDLE;
        eff_branch = 1'b1;
      end else if (cnt_r != 3'd0) begin
        eff_state = FLUSH;
      end else begin
        eff_state = IDLE;
      end
    end else begin
      eff_state = state_r;
    end

    if (bus.MemBusy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      hold_s      = 1'b1;
      state_n     = MEMWAIT;
      pend_n      = pend_r | bus.BranchTaken;
    end else begin
      pend_n = 1'b0;
      case (eff_state)
        FLUSH: begin
          flush_s = 1'b1;
          if (eff_branch) begin
            cnt_n = FC_RELOAD;
          end else if (cnt_r != 3'd0) begin
            cnt_n = cnt_r - 3'd1;
          end else begin
            cnt_n = 3'd0;
          end
          state_n = (cnt_n != 3'd0) ? FLUSH : IDLE;
        end
        IDLE: begin
          if (eff_branch) begin
            flush_s = 1'b1;
            cnt_n   = FC_RELOAD;
            state_n = (FC_RELOAD != 3'd0) ? FLUSH : IDLE;
          end else if (hazard) begin
            stall_s     = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            cnt_n       = 3'd0;
            state_n     = IDLE;
          end else begin
            cnt_n   = 3'd0;
            state_n = IDLE;
          end
        end
        default: begin
          cnt_n   = 3'd0;
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.PCWrite     = Reset_n & pc_write;
  assign bus.IF_ID_Write = Reset_n & if_id_write;
  assign bus.IF_ID_Flush = ~Reset_n | flush_s;
  assign bus.ID_EX_Flush = ~Reset_n | flush_s | stall_s;
  assign bus.EX_MEM_Hold = Reset_n & hold_s;
  assign bus.StallActive = Reset_n & stall_s;

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Saturating statistics counters for stall and flush cycles
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_s && (stall_cnt_r != '1)) stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      if (flush_s && (flush_cnt_r != '1)) flush_cnt_r <= flush_cnt_r + CNT_W'(1);
    end
  end

  assign bus.StallCount = stall_cnt_r;
  assign bus.FlushCount = flush_cnt_r;
`else
  assign bus.StallCount = '0;
  assign bus.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc. Two instances share stimulus:
// u1 (LOAD_LAT=1, FLUSH_CYCLES=2) and u3 (LOAD_LAT=3, FLUSH_CYCLES=2).
// Expected outputs are queued as each step is driven and checked at the
// following falling edge.
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold, StallActive}
  localparam logic [5:0] RUN = 6'b110000;
  localparam logic [5:0] STL = 6'b000101;
  localparam logic [5:0] FLS = 6'b111100;
  localparam logic [5:0] FRZ = 6'b000010;
  localparam logic [5:0] RST = 6'b001100;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct {
    string      tag;
    logic [5:0] e1;
    logic [5:0] e3;
  } exp_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   st1, st3, fl1, fl3;
  exp_t sb[$];

  hazard_ctrl_mc_if #(.REG_W(5), .CNT_W(32)) if1 ();
  hazard_ctrl_mc_if #(.REG_W(5), .CNT_W(32)) if3 ();

  hazard_ctrl_mc #(.REG_W(5), .LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(32)) u1 (
    .Clk(clk), .Reset_n(rst_n), .bus(if1)
  );
  hazard_ctrl_mc #(.REG_W(5), .LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(32)) u3 (
    .Clk(clk), .Reset_n(rst_n), .bus(if3)
  );

  logic [5:0] o1, o3;
  assign o1 = {if1.PCWrite, if1.IF_ID_Write, if1.IF_ID_Flush, if1.ID_EX_Flush, if1.EX_MEM_Hold, if1.StallActive};
  assign o3 = {if3.PCWrite, if3.IF_ID_Write, if3.IF_ID_Flush, if3.ID_EX_Flush, if3.EX_MEM_Hold, if3.StallActive};

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    compared++;
    assert (o1 === e.e1) else begin
      mismatched++;
      $error("FAIL %s ll1 got %b want %b", e.tag, o1, e.e1);
    end
    compared++;
    assert (o3 === e.e3) else begin
      mismatched++;
      $error("FAIL %s ll3 got %b want %b", e.tag, o3, e.e3);
    end
  endtask

  // One clock of stimulus: drive, queue expectation, check at falling edge
  task automatic step(input string tag, input logic r, input logic [31:0] instr,
                      input logic mr, input logic [4:0] rt, input logic bt, input logic mb,
                      input logic [5:0] e1, input logic [5:0] e3);
    exp_t e;
    rst_n = r;
    if1.ID_Instruction = instr; if3.ID_Instruction = instr;
    if1.EX_MemRead = mr;        if3.EX_MemRead = mr;
    if1.EX_RtReg = rt;          if3.EX_RtReg = rt;
    if1.BranchTaken = bt;       if3.BranchTaken = bt;
    if1.MemBusy = mb;           if3.MemBusy = mb;
    e.tag = tag; e.e1 = e1; e.e3 = e3;
    sb.push_back(e);
    if (!r) begin
      st1 = 0; st3 = 0; fl1 = 0; fl3 = 0;
    end else begin
      st1 += int'(e1[0]); st3 += int'(e3[0]);
      fl1 += int'(e1[3]); fl3 += int'(e3[3]);
    end
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    logic [31:0] x1s, x3s, x1f, x3f;
`ifdef STALL_STATS_EN
    x1s = 32'(st1); x3s = 32'(st3); x1f = 32'(fl1); x3f = 32'(fl3);
`else
    x1s = 32'd0; x3s = 32'd0; x1f = 32'd0; x3f = 32'd0;
`endif
    compared++;
    assert (if1.StallCount === x1s) else begin
      mismatched++; $error("FAIL %s ll1 StallCount got %0d want %0d", tag, if1.StallCount, x1s);
    end
    compared++;
    assert (if3.StallCount === x3s) else begin
      mismatched++; $error("FAIL %s ll3 StallCount got %0d want %0d", tag, if3.StallCount, x3s);
    end
    compared++;
    assert (if1.FlushCount === x1f) else begin
      mismatched++; $error("FAIL %s ll1 FlushCount got %0d want %0d", tag, if1.FlushCount, x1f);
    end
    compared++;
    assert (if3.FlushCount === x3f) else begin
      mismatched++; $error("FAIL %s ll3 FlushCount got %0d want %0d", tag, if3.FlushCount, x3f);
    end
  endtask

  initial begin
    logic [31:0] add_3, beq_5, add_0, j_4, lui_4, addi_4, sw_4, add_7;
    compared = 0; mismatched = 0;
    st1 = 0; st3 = 0; fl1 = 0; fl3 = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    add_3  = mk(OP_RTYPE, 5'd2, 5'd3);
    beq_5  = mk(OP_BEQ, 5'd5, 5'd0);
    add_0  = mk(OP_RTYPE, 5'd0, 5'd0);
    j_4    = mk(OP_J, 5'd4, 5'd4);
    lui_4  = mk(OP_LUI, 5'd4, 5'd4);
    addi_4 = mk(6'b001000, 5'd6, 5'd4);
    sw_4   = mk(OP_SW, 5'd6, 5'd4);
    add_7  = mk(OP_RTYPE, 5'd7, 5'd1);
    #1;

    // reset state
    step("reset", 1'b0, NOP, 1'b0, 5'd0, 1'b0, 1'b0, RST, RST);
    check_counts("reset_cnt");
    step("idle", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // lw $3 in EX, add $1,$2,$3 in ID
    step("lu3_a", 1'b1, add_3, 1'b1, 5'd3, 1'b0, 1'b0, STL, STL);
    step("lu3_b", 1'b1, add_3, 1'b0, 5'd0, 1'b0, 1'b0, RUN, STL);
    step("lu3_c", 1'b1, add_3, 1'b0, 5'd0, 1'b0, 1'b0, RUN, STL);
    step("lu3_d", 1'b1, add_3, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // lw $5 then beq $5,$0
    step("lu5_a", 1'b1, beq_5, 1'b1, 5'd5, 1'b0, 1'b0, STL, STL);
    step("lu5_b", 1'b1, beq_5, 1'b0, 5'd0, 1'b0, 1'b0, RUN, STL);
    step("lu5_c", 1'b1, beq_5, 1'b0, 5'd0, 1'b0, 1'b0, RUN, STL);
    step("lu5_d", 1'b1, beq_5, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // register 0 never hazards
    step("reg0", 1'b1, add_0, 1'b1, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // source decode: J / LUI / ADDI-rt do not use $4, SW does
    step("j_4",    1'b1, j_4,    1'b1, 5'd4, 1'b0, 1'b0, RUN, RUN);
    step("lui_4",  1'b1, lui_4,  1'b1, 5'd4, 1'b0, 1'b0, RUN, RUN);
    step("addi_4", 1'b1, addi_4, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);
    step("sw_4",   1'b1, sw_4,   1'b1, 5'd4, 1'b0, 1'b0, STL, STL);
    step("drain1", 1'b1, NOP,    1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);
    step("drain2", 1'b1, NOP,    1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // two-cycle branch flush
    step("br_a", 1'b1, NOP, 1'b0, 5'd0, 1'b1, 1'b0, FLS, FLS);
    step("br_b", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, FLS, FLS);
    step("br_c", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // MemBusy in the second flush cycle freezes, flush finishes after release
    step("brm_a", 1'b1, NOP, 1'b0, 5'd0, 1'b1, 1'b0, FLS, FLS);
    step("brm_b", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b1, FRZ, FRZ);
    step("brm_c", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b1, FRZ, FRZ);
    step("brm_d", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, FLS, FLS);
    step("brm_e", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // hazard together with branch: flush wins, squashed load not tracked
    step("hzbr_a", 1'b1, add_3, 1'b1, 5'd3, 1'b1, 1'b0, FLS, FLS);
    step("hzbr_b", 1'b1, add_3, 1'b0, 5'd0, 1'b0, 1'b0, FLS, FLS);
    step("hzbr_c", 1'b1, add_3, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // branch arriving during MEMWAIT flushes after release
    step("pend_a", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b1, FRZ, FRZ);
    step("pend_b", 1'b1, NOP, 1'b0, 5'd0, 1'b1, 1'b1, FRZ, FRZ);
    step("pend_c", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, FLS, FLS);
    step("pend_d", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, FLS, FLS);
    step("pend_e", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    // 4 cycles MemBusy with a load in flight; stalls resume afterwards
    step("mb_a", 1'b1, add_7, 1'b1, 5'd7, 1'b0, 1'b0, STL, STL);
    for (int i = 0; i < 4; i++) begin
      step("mb_frz", 1'b1, add_7, 1'b0, 5'd0, 1'b0, 1'b1, FRZ, FRZ);
    end
    step("mb_b", 1'b1, add_7, 1'b0, 5'd0, 1'b0, 1'b0, RUN, STL);
    step("mb_c", 1'b1, add_7, 1'b0, 5'd0, 1'b0, 1'b0, RUN, STL);
    step("mb_d", 1'b1, add_7, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);
    check_counts("stats");

    // reset pulse in the middle of a flush
    step("rf_a", 1'b1, NOP, 1'b0, 5'd0, 1'b1, 1'b0, FLS, FLS);
    step("rf_rst", 1'b0, NOP, 1'b0, 5'd0, 1'b0, 1'b0, RST, RST);
    check_counts("rst_cnt");
    step("rf_b", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);
    step("rf_c", 1'b1, NOP, 1'b0, 5'd0, 1'b0, 1'b0, RUN, RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
